ddr4_cmd_decode: RTL and testbench

DDR4_CMD_DECODE -- requirements
Module: ddr4_cmd_decode

---
 rtl/ddr4_pkg.sv | 87 ++++++++
 rtl/ddr4_ca_parity.sv | 19 +
 rtl/ddr4_cmd_decode.sv | 189 ++++++++++++++++++
 tb/tb_ddr4_cmd_decode.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared DDR4 command-decode types: power states, decoded commands,
// RAS_n/CAS_n/WE_n encodings, strobe bit positions and the CA parity helper.
package ddr4_pkg;

  typedef enum logic [1:0] {
    ON      = 2'd0,
    PWRDN   = 2'd1,
    SELFREF = 2'd2
  } pwr_state_e;

  typedef enum logic [3:0] {
    CMD_NONE    = 4'd0,
    CMD_ACT     = 4'd1,
    CMD_RD      = 4'd2,
    CMD_RDA     = 4'd3,
    CMD_WR      = 4'd4,
    CMD_WRA     = 4'd5,
    CMD_PR      = 4'd6,
    CMD_PRA     = 4'd7,
    CMD_REF     = 4'd8,
    CMD_SRF     = 4'd9,
    CMD_MRW     = 4'd10,
    CMD_CFG     = 4'd11,
    CMD_PD      = 4'd12,
    CMD_PDX     = 4'd13,
    CMD_ILLEGAL = 4'd14
  } dec_cmd_e;

  localparam logic [2:0] RCW_MRW = 3'b000;
  localparam logic [2:0] RCW_REF = 3'b001;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_RFU = 3'b011;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_ZQ  = 3'b110;
  localparam logic [2:0] RCW_NOP = 3'b111;

  localparam int AP_BIT = 10;

  localparam int STB_W   = 13;
  localparam int STB_ACT = 0;
  localparam int STB_RD  = 1;
  localparam int STB_RDA = 2;
  localparam int STB_WR  = 3;
  localparam int STB_WRA = 4;
  localparam int STB_PR  = 5;
  localparam int STB_PRA = 6;
  localparam int STB_REF = 7;
  localparam int STB_SRF = 8;
  localparam int STB_MRW = 9;
  localparam int STB_CFG = 10;
  localparam int STB_PD  = 11;
  localparam int STB_PDX = 12;

  // One-hot strobe vector for a decoded command; NONE and ILLEGAL map to all-zero.
  function automatic logic [STB_W-1:0] cmd_to_strobe(input dec_cmd_e cmd);
    logic [STB_W-1:0] s;
    s = {STB_W{1'b0}};
    case (cmd)
      CMD_ACT: s[STB_ACT] = 1'b1;
      CMD_RD:  s[STB_RD]  = 1'b1;
      CMD_RDA: s[STB_RDA] = 1'b1;
      CMD_WR:  s[STB_WR]  = 1'b1;
      CMD_WRA: s[STB_WRA] = 1'b1;
      CMD_PR:  s[STB_PR]  = 1'b1;
      CMD_PRA: s[STB_PRA] = 1'b1;
      CMD_REF: s[STB_REF] = 1'b1;
      CMD_SRF: s[STB_SRF] = 1'b1;
      CMD_MRW: s[STB_MRW] = 1'b1;
      CMD_CFG: s[STB_CFG] = 1'b1;
      CMD_PD:  s[STB_PD]  = 1'b1;
      CMD_PDX: s[STB_PDX] = 1'b1;
      default: s = {STB_W{1'b0}};
    endcase
    return s;
  endfunction

  // Reduction over the CA bus including par; a correct even-parity bus yields 0.
  function automatic logic ca_parity(input logic        act_n,
                                     input logic [16:0] adr,
                                     input logic [1:0]  bg,
                                     input logic [1:0]  ba,
                                     input logic        par);
    return ^{act_n, adr, bg, ba, par};
  endfunction

endpackage

// File: rtl/ddr4_ca_parity.sv
// CA even-parity checker; flags a mismatch only on cycles where the chip is selected.
module ddr4_ca_parity
  import ddr4_pkg::*;
(
  input  logic        i_chk,
  input  logic        i_act_n,
  input  logic [16:0] i_adr,
  input  logic [1:0]  i_bg,
  input  logic [1:0]  i_ba,
  input  logic        i_par,
  output logic        o_err
);

  // Mismatch when the selected CA bus does not XOR to zero.
  always_comb begin
    o_err = i_chk & ca_parity(i_act_n, i_adr, i_bg, i_ba, i_par);
  end

endmodule

// File: rtl/ddr4_cmd_decode.sv
// DDR4 CA decoder: registered one-cycle command strobes, power-state FSM and sticky halt.
// Defining DDR4_CA_PARITY_EN adds the CA even-parity check (ddr4_ca_parity).
module ddr4_cmd_decode
  import ddr4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic [16:0] adr,
  input  logic [1:0]  ba,
  input  logic [1:0]  bg,
  input  logic        par,
  output logic        ACT,
  output logic        RD,
  output logic        RDA,
  output logic        WR,
  output logic        WRA,
  output logic        PR,
  output logic        PRA,
  output logic        REF,
  output logic        SRF,
  output logic        MRW,
  output logic        CFG,
  output logic        PD,
  output logic        PDX,
  output logic        BST,
  output logic        MRR,
  output logic        DPD,
  output logic        DPDX,
  output logic        CKEH,
  output logic        CKEL,
  output logic        halt,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [16:0] cmd_adr
);

  pwr_state_e       r_state;
  pwr_state_e       w_state_nxt;
  dec_cmd_e         w_cmd;
  logic             r_prev_cke;
  logic             r_ckel;
  logic             r_halt;
  logic [STB_W-1:0] r_strb;
  logic [STB_W-1:0] w_strb_nxt;
  logic [1:0]       r_bg;
  logic [1:0]       r_ba;
  logic [16:0]      r_adr;
  logic [2:0]       w_rcw;
  logic             w_ap;
  logic             w_nop;
  logic             w_is_ref;
  logic             w_fall;
  logic             w_rise;
  logic             w_par_err;
  logic             w_illegal;

  assign w_rcw    = adr[16:14];
  assign w_ap     = adr[AP_BIT];
  assign w_nop    = cs_n | (act_n & (w_rcw == RCW_NOP));
  assign w_is_ref = ~cs_n & act_n & (w_rcw == RCW_REF);
  assign w_fall   = r_prev_cke & ~cke;
  assign w_rise   = ~r_prev_cke & cke;

`ifdef DDR4_CA_PARITY_EN
  ddr4_ca_parity u_ca_parity (
    .i_chk   (~cs_n),
    .i_act_n (act_n),
    .i_adr   (adr),
    .i_bg    (bg),
    .i_ba    (ba),
    .i_par   (par),
    .o_err   (w_par_err)
  );
`else
  logic w_unused_par;
  assign w_unused_par = par;
  assign w_par_err    = 1'b0;
`endif

  // Command decode and next power state; cke edges are judged against the registered cke.
  always_comb begin
    w_cmd       = CMD_NONE;
    w_state_nxt = r_state;
    case (r_state)
      ON: begin
        if (w_fall) begin
          if (w_nop) begin
            w_cmd       = CMD_PD;
            w_state_nxt = PWRDN;
          end else if (w_is_ref) begin
            w_cmd       = CMD_SRF;
            w_state_nxt = SELFREF;
          end else begin
            w_cmd = CMD_ILLEGAL;
          end
        end else if (!cke) begin
          if (w_nop) begin
            w_cmd = CMD_NONE;
          end else begin
            w_cmd = CMD_ILLEGAL;
          end
        end else if (w_nop) begin
          w_cmd = CMD_NONE;
        end else if (!act_n) begin
          w_cmd = CMD_ACT;
        end else begin
          case (w_rcw)
            RCW_MRW: w_cmd = CMD_MRW;
            RCW_REF: w_cmd = CMD_REF;
            RCW_PRE: w_cmd = w_ap ? CMD_PRA : CMD_PR;
            RCW_WR:  w_cmd = w_ap ? CMD_WRA : CMD_WR;
            RCW_RD:  w_cmd = w_ap ? CMD_RDA : CMD_RD;
            RCW_ZQ:  w_cmd = CMD_CFG;
            RCW_NOP: w_cmd = CMD_NONE;
            default: w_cmd = CMD_ILLEGAL;
          endcase
        end
      end
      PWRDN, SELFREF: begin
        if (!w_nop) begin
          w_cmd = CMD_ILLEGAL;
        end else if (w_rise) begin
          w_cmd       = CMD_PDX;
          w_state_nxt = ON;
        end else begin
          w_cmd = CMD_NONE;
        end
      end
      default: begin
        w_cmd       = CMD_NONE;
        w_state_nxt = PWRDN;
      end
    endcase
  end

  // Illegal or parity-failed commands, and anything while halted, produce no strobe.
  always_comb begin
    w_illegal = (w_cmd == CMD_ILLEGAL) | w_par_err;
    if (w_illegal || r_halt) begin
      w_strb_nxt = {STB_W{1'b0}};
    end else begin
      w_strb_nxt = cmd_to_strobe(w_cmd);
    end
  end

  // State, strobe, halt and CA-field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= PWRDN;
      r_prev_cke <= 1'b0;
      r_ckel     <= 1'b1;
      r_halt     <= 1'b0;
      r_strb     <= {STB_W{1'b0}};
      r_bg       <= 2'd0;
      r_ba       <= 2'd0;
      r_adr      <= 17'd0;
    end else begin
      r_prev_cke <= cke;
      r_ckel     <= ~cke;
      r_strb     <= w_strb_nxt;
      if (w_illegal) begin
        r_halt <= 1'b1;
      end else begin
        r_state <= w_state_nxt;
      end
      if (|w_strb_nxt) begin
        r_bg  <= bg;
        r_ba  <= ba;
        r_adr <= adr;
      end
    end
  end

  assign {PDX, PD, CFG, MRW, SRF, REF, PRA, PR, WRA, WR, RDA, RD, ACT} = r_strb;
  assign BST     = 1'b0;
  assign MRR     = 1'b0;
  assign DPD     = 1'b0;
  assign DPDX    = 1'b0;
  assign CKEH    = r_prev_cke;
  assign CKEL    = r_ckel;
  assign halt    = r_halt;
  assign cmd_bg  = r_bg;
  assign cmd_ba  = r_ba;
  assign cmd_adr = r_adr;

endmodule

// File: tb/tb_ddr4_cmd_decode.sv
// Table-driven bench for ddr4_cmd_decode plus a hand-written reset/pulse-width sequence.
module tb_ddr4_cmd_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cke = 1'b0;
  logic        cs_n = 1'b1;
  logic        act_n = 1'b1;
  logic [16:0] adr = 17'd0;
  logic [1:0]  ba = 2'd0;
  logic [1:0]  bg = 2'd0;
  logic        par = 1'b0;
  logic ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, CFG, PD, PDX;
  logic BST, MRR, DPD, DPDX, CKEH, CKEL, halt;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [16:0] cmd_adr;
  logic [12:0] got_strb;

  int checks = 0;
  int failures = 0;

  localparam logic [12:0] S_0   = 13'h0000;
  localparam logic [12:0] S_ACT = 13'h0001;
  localparam logic [12:0] S_RD  = 13'h0002;
  localparam logic [12:0] S_RDA = 13'h0004;
  localparam logic [12:0] S_WR  = 13'h0008;
  localparam logic [12:0] S_WRA = 13'h0010;
  localparam logic [12:0] S_PR  = 13'h0020;
  localparam logic [12:0] S_PRA = 13'h0040;
  localparam logic [12:0] S_REF = 13'h0080;
  localparam logic [12:0] S_SRF = 13'h0100;
  localparam logic [12:0] S_MRW = 13'h0200;
  localparam logic [12:0] S_CFG = 13'h0400;
  localparam logic [12:0] S_PD  = 13'h0800;
  localparam logic [12:0] S_PDX = 13'h1000;

  typedef struct packed {
    logic        rst;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [16:0] adr;
    logic [1:0]  ba;
    logic [1:0]  bg;
    logic        flip;
    logic [12:0] e_strb;
    logic        e_halt;
    logic        e_ckeh;
    logic [1:0]  e_bg;
    logic [1:0]  e_ba;
    logic [16:0] e_adr;
  } vec_t;

  vec_t vq[$];

  ddr4_cmd_decode dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .adr(adr),
    .ba(ba), .bg(bg), .par(par),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA),
    .REF(REF), .SRF(SRF), .MRW(MRW), .CFG(CFG), .PD(PD), .PDX(PDX),
    .BST(BST), .MRR(MRR), .DPD(DPD), .DPDX(DPDX), .CKEH(CKEH), .CKEL(CKEL),
    .halt(halt), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_adr(cmd_adr)
  );

  assign got_strb = {PDX, PD, CFG, MRW, SRF, REF, PRA, PR, WRA, WR, RDA, RD, ACT};

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic k, input logic c, input logic a,
                     input logic [16:0] ad, input logic [1:0] b, input logic [1:0] g,
                     input logic f, input logic [12:0] es, input logic eh, input logic ek,
                     input logic [1:0] eg, input logic [1:0] eb, input logic [16:0] ea);
    vec_t v;
    v.rst = r; v.cke = k; v.cs_n = c; v.act_n = a; v.adr = ad; v.ba = b; v.bg = g;
    v.flip = f; v.e_strb = es; v.e_halt = eh; v.e_ckeh = ek;
    v.e_bg = eg; v.e_ba = eb; v.e_adr = ea;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, idx, got, exp);
    end
  endtask

  // Drive one CA sample at the falling edge; par is even parity, optionally inverted.
  task automatic drive(input logic r, input logic k, input logic c, input logic a,
                       input logic [16:0] ad, input logic [1:0] b, input logic [1:0] g,
                       input logic f);
    @(negedge clk);
    rst = r; cke = k; cs_n = c; act_n = a; adr = ad; ba = b; bg = g;
    par = (^{a, ad, g, b}) ^ f;
  endtask

  initial begin
    // Phase A: reset, PDX, every command type, power-down / self-refresh, illegal in SELFREF
    add(0,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(0,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,1,0,0,17'h01234,2'd1,2'd2,0, S_ACT,0,1, 2'd2,2'd1,17'h01234);
    add(1,1,0,1,17'h1C055,2'd3,2'd3,0, S_0,  0,1, 2'd2,2'd1,17'h01234);
    add(1,1,0,1,17'h14412,2'd2,2'd1,0, S_RDA,0,1, 2'd1,2'd2,17'h14412);
    add(1,1,0,1,17'h08400,2'd0,2'd3,0, S_PRA,0,1, 2'd3,2'd0,17'h08400);
    add(1,1,0,1,17'h14ABC,2'd1,2'd0,0, S_RD, 0,1, 2'd0,2'd1,17'h14ABC);
    add(1,1,0,1,17'h10003,2'd3,2'd0,0, S_WR, 0,1, 2'd0,2'd3,17'h10003);
    add(1,1,0,1,17'h10400,2'd2,2'd2,0, S_WRA,0,1, 2'd2,2'd2,17'h10400);
    add(1,1,0,1,17'h08000,2'd1,2'd1,0, S_PR, 0,1, 2'd1,2'd1,17'h08000);
    add(1,1,0,1,17'h00155,2'd0,2'd1,0, S_MRW,0,1, 2'd1,2'd0,17'h00155);
    add(1,1,0,1,17'h18000,2'd0,2'd0,0, S_CFG,0,1, 2'd0,2'd0,17'h18000);
    add(1,1,0,1,17'h04000,2'd0,2'd0,0, S_REF,0,1, 2'd0,2'd0,17'h04000);
    add(1,0,1,1,17'h00000,2'd0,2'd0,0, S_PD, 0,0, 2'd0,2'd0,17'h00000);
    add(1,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,0,0,1,17'h04000,2'd1,2'd1,0, S_SRF,0,0, 2'd1,2'd1,17'h04000);
    add(1,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd1,2'd1,17'h04000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,0,0,1,17'h04000,2'd0,2'd0,0, S_SRF,0,0, 2'd0,2'd0,17'h04000);
    add(1,0,0,1,17'h14000,2'd2,2'd2,0, S_0,  1,0, 2'd0,2'd0,17'h04000);
    add(1,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  1,0, 2'd0,2'd0,17'h04000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_0,  1,1, 2'd0,2'd0,17'h04000);
    add(1,1,0,0,17'h00ABC,2'd1,2'd1,0, S_0,  1,1, 2'd0,2'd0,17'h04000);
    // Phase B: RFU encoding halts, following WR is blocked
    add(0,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,1,0,1,17'h0C000,2'd1,2'd1,0, S_0,  1,1, 2'd0,2'd0,17'h00000);
    add(1,1,0,1,17'h10000,2'd2,2'd2,0, S_0,  1,1, 2'd0,2'd0,17'h00000);
    // Phase C: cke fall together with RD is illegal
    add(0,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,0,0,1,17'h14000,2'd1,2'd1,0, S_0,  1,0, 2'd0,2'd0,17'h00000);
    // Phase D: good ACT, then ACT with parity inverted
    add(0,0,1,1,17'h00000,2'd0,2'd0,0, S_0,  0,0, 2'd0,2'd0,17'h00000);
    add(1,1,1,1,17'h00000,2'd0,2'd0,0, S_PDX,0,1, 2'd0,2'd0,17'h00000);
    add(1,1,0,0,17'h01111,2'd0,2'd1,0, S_ACT,0,1, 2'd1,2'd0,17'h01111);
`ifdef DDR4_CA_PARITY_EN
    add(1,1,0,0,17'h00777,2'd3,2'd1,1, S_0,  1,1, 2'd1,2'd0,17'h01111);
`else
    add(1,1,0,0,17'h00777,2'd3,2'd1,1, S_ACT,0,1, 2'd1,2'd3,17'h00777);
`endif

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].cke, vq[i].cs_n, vq[i].act_n, vq[i].adr, vq[i].ba, vq[i].bg, vq[i].flip);
      @(posedge clk);
      #1;
      chk("strobes", i, {19'd0, got_strb}, {19'd0, vq[i].e_strb});
      chk("halt",    i, {31'd0, halt},     {31'd0, vq[i].e_halt});
      chk("ckeh",    i, {31'd0, CKEH},     {31'd0, vq[i].e_ckeh});
      chk("ckel",    i, {31'd0, CKEL},     {31'd0, ~vq[i].e_ckeh});
      chk("cmd_bg",  i, {30'd0, cmd_bg},   {30'd0, vq[i].e_bg});
      chk("cmd_ba",  i, {30'd0, cmd_ba},   {30'd0, vq[i].e_ba});
      chk("cmd_adr", i, {15'd0, cmd_adr},  {15'd0, vq[i].e_adr});
      chk("lpddr_tied", i, {28'd0, BST, MRR, DPD, DPDX}, 32'd0);
    end

    // Reset asserted with an ACT on the bus discards it
    drive(0, 1, 0, 0, 17'h02222, 2'd1, 2'd1, 0);
    @(posedge clk); #1;
    chk("rst_mid_act", 100, {31'd0, ACT}, 32'd0);
    chk("rst_mid_adr", 100, {15'd0, cmd_adr}, 32'd0);
    chk("rst_mid_halt", 100, {31'd0, halt}, 32'd0);
    drive(1, 1, 1, 1, 17'h00000, 2'd0, 2'd0, 0);
    @(posedge clk); #1;
    chk("first_rise_pdx", 101, {31'd0, PDX}, 32'd1);
    drive(1, 1, 0, 0, 17'h02222, 2'd1, 2'd1, 0);
    @(posedge clk); #1;
    chk("act_pulse_hi", 102, {31'd0, ACT}, 32'd1);
    chk("act_pulse_adr", 102, {15'd0, cmd_adr}, 32'h02222);
    drive(1, 1, 1, 1, 17'h00000, 2'd0, 2'd0, 0);
    @(posedge clk); #1;
    chk("act_pulse_lo", 103, {31'd0, ACT}, 32'd0);
    chk("act_hold_adr", 103, {15'd0, cmd_adr}, 32'h02222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
